// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, memory freeze,
// halt drain, plus saturating debug event counters and sticky halt/timeout flags.
module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MEM_TIMEOUT  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IDEXMemRead,
    input  logic [3:0]  idex_dst,
    input  logic [3:0]  ifid_rs,
    input  logic [3:0]  ifid_rt,
    input  logic        ifid_uses_rs,
    input  logic        ifid_uses_rt,
    input  logic        id_halt,
    input  logic        ex_branch_taken,
    input  logic        mem_stall,
    output logic        wr_PC,
    output logic        wr_IFID,
    output logic        IFIDclear,
    output logic        wr_IDEX,
    output logic        IDEXclear,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    localparam logic [3:0] DrainInit  = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] MemTimeout = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [3:0]  drain_q, drain_d;
    logic [7:0]  memw_q, memw_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;
    logic        halted_q, halted_d;
    logic        mem_err_q, mem_err_d;
    logic        lu;
    logic        timeout;

    assign lu = IDEXMemRead && (idex_dst != 4'd0) &&
                ((ifid_uses_rs && (ifid_rs == idex_dst)) ||
                 (ifid_uses_rt && (ifid_rt == idex_dst)));

    // The stall cycle that brings the wait count up to the limit is the one that trips.
    assign timeout = mem_stall && ((memw_q + 8'd1) == MemTimeout);

    always_comb begin
        wr_PC         = 1'b0;
        wr_IFID       = 1'b0;
        IFIDclear     = 1'b0;
        wr_IDEX       = 1'b0;
        IDEXclear     = 1'b0;
        state_d       = state_q;
        drain_d       = drain_q;
        memw_d        = 8'd0;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        halted_d      = halted_q;
        mem_err_d     = mem_err_q;

        if (reset) begin
            IFIDclear = 1'b1;
            IDEXclear = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mem_stall) begin
                        memw_d = memw_q + 8'd1;
                        if (timeout) begin
                            mem_err_d = 1'b1;
                            halted_d  = 1'b1;
                            state_d   = StHalted;
                        end
                    end else if (ex_branch_taken) begin
                        wr_PC     = 1'b1;
                        IFIDclear = 1'b1;
                        IDEXclear = 1'b1;
                        if (flush_count_q != 16'hFFFF) flush_count_d = flush_count_q + 16'd1;
                    end else if (lu) begin
                        IDEXclear = 1'b1;
                        if (stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
                    end else if (id_halt) begin
                        IDEXclear = 1'b1;
                        drain_d   = DrainInit;
                        state_d   = StDrain;
                    end else begin
                        wr_PC   = 1'b1;
                        wr_IFID = 1'b1;
                        wr_IDEX = 1'b1;
                    end
                end
                StDrain: begin
                    if (mem_stall) begin
                        memw_d = memw_q + 8'd1;
                        if (timeout) begin
                            mem_err_d = 1'b1;
                            halted_d  = 1'b1;
                            state_d   = StHalted;
                        end
                    end else begin
                        IDEXclear = 1'b1;
                        if (drain_q == 4'd0) begin
                            halted_d = 1'b1;
                            state_d  = StHalted;
                        end else begin
                            drain_d = drain_q - 4'd1;
                        end
                    end
                end
                StHalted: begin
                    IFIDclear = 1'b1;
                    IDEXclear = 1'b1;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            drain_q       <= 4'd0;
            memw_q        <= 8'd0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
            halted_q      <= 1'b0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            memw_q        <= memw_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            halted_q      <= halted_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign halted      = halted_q;
    assign mem_err     = mem_err_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; inputs change 1ns after posedge, outputs sampled mid-cycle.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        IDEXMemRead;
    logic [3:0]  idex_dst;
    logic [3:0]  ifid_rs;
    logic [3:0]  ifid_rt;
    logic        ifid_uses_rs;
    logic        ifid_uses_rt;
    logic        id_halt;
    logic        ex_branch_taken;
    logic        mem_stall;
    logic        wr_PC;
    logic        wr_IFID;
    logic        IFIDclear;
    logic        wr_IDEX;
    logic        IDEXclear;
    logic        halted;
    logic        mem_err;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int tests = 0;
    int fails = 0;

    // {wr_PC, wr_IFID, IFIDclear, wr_IDEX, IDEXclear}
    logic [4:0] ctl;
    assign ctl = {wr_PC, wr_IFID, IFIDclear, wr_IDEX, IDEXclear};

    localparam logic [4:0] CtlReset  = 5'b00101;
    localparam logic [4:0] CtlNormal = 5'b11010;
    localparam logic [4:0] CtlBubble = 5'b00001;
    localparam logic [4:0] CtlFlush  = 5'b10101;
    localparam logic [4:0] CtlFreeze = 5'b00000;

    hazard_ctrl #(
        .DRAIN_CYCLES(3),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .IDEXMemRead    (IDEXMemRead),
        .idex_dst       (idex_dst),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .ifid_uses_rs   (ifid_uses_rs),
        .ifid_uses_rt   (ifid_uses_rt),
        .id_halt        (id_halt),
        .ex_branch_taken(ex_branch_taken),
        .mem_stall      (mem_stall),
        .wr_PC          (wr_PC),
        .wr_IFID        (wr_IFID),
        .IFIDclear      (IFIDclear),
        .wr_IDEX        (wr_IDEX),
        .IDEXclear      (IDEXclear),
        .halted         (halted),
        .mem_err        (mem_err),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IDEXMemRead     = 1'b0;
        idex_dst        = 4'd0;
        ifid_rs         = 4'd0;
        ifid_rt         = 4'd0;
        ifid_uses_rs    = 1'b0;
        ifid_uses_rt    = 1'b0;
        id_halt         = 1'b0;
        ex_branch_taken = 1'b0;
        mem_stall       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        #2;
        tests++;
        if (ctl !== CtlReset) begin
            fails++; $display("FAIL reset_ctl got=%b want=%b", ctl, CtlReset);
        end
        tick();
        reset = 1'b0;
        #2;
        tests++;
        if (ctl !== CtlNormal) begin
            fails++; $display("FAIL post_reset_ctl got=%b want=%b", ctl, CtlNormal);
        end
        tests++;
        if ({stall_count, flush_count, halted, mem_err} !== 34'd0) begin
            fails++; $display("FAIL post_reset_state got=%h/%h/%b/%b want=0/0/0/0",
                              stall_count, flush_count, halted, mem_err);
        end
    endtask

    task automatic test_load_use();
        IDEXMemRead = 1'b1; idex_dst = 4'd3; ifid_rs = 4'd3; ifid_uses_rs = 1'b1;
        #2;
        tests++;
        if (ctl !== CtlBubble) begin
            fails++; $display("FAIL lu_rs_ctl got=%b want=%b", ctl, CtlBubble);
        end
        tick();
        idle_inputs();
        tests++;
        if (stall_count !== 16'd1) begin
            fails++; $display("FAIL lu_rs_count got=%0d want=1", stall_count);
        end
        // Register 0 never hazards.
        IDEXMemRead = 1'b1; idex_dst = 4'd0; ifid_rs = 4'd0; ifid_uses_rs = 1'b1;
        #2;
        tests++;
        if (ctl !== CtlNormal) begin
            fails++; $display("FAIL lu_r0_ctl got=%b want=%b", ctl, CtlNormal);
        end
        tick();
        tests++;
        if (stall_count !== 16'd1) begin
            fails++; $display("FAIL lu_r0_count got=%0d want=1", stall_count);
        end
        // Matching rs without uses_rs is not a hazard.
        IDEXMemRead = 1'b1; idex_dst = 4'd5; ifid_rs = 4'd5; ifid_uses_rs = 1'b0;
        ifid_rt = 4'd5; ifid_uses_rt = 1'b0;
        #2;
        tests++;
        if (ctl !== CtlNormal) begin
            fails++; $display("FAIL lu_nouse_ctl got=%b want=%b", ctl, CtlNormal);
        end
        ifid_uses_rt = 1'b1;
        #2;
        tests++;
        if (ctl !== CtlBubble) begin
            fails++; $display("FAIL lu_rt_ctl got=%b want=%b", ctl, CtlBubble);
        end
        tick();
        idle_inputs();
        tests++;
        if (stall_count !== 16'd2) begin
            fails++; $display("FAIL lu_rt_count got=%0d want=2", stall_count);
        end
    endtask

    task automatic test_branch();
        IDEXMemRead = 1'b1; idex_dst = 4'd3; ifid_rs = 4'd3; ifid_uses_rs = 1'b1;
        ex_branch_taken = 1'b1;
        #2;
        tests++;
        if (ctl !== CtlFlush) begin
            fails++; $display("FAIL branch_ctl got=%b want=%b", ctl, CtlFlush);
        end
        tick();
        idle_inputs();
        tests++;
        if ({flush_count, stall_count} !== {16'd1, 16'd2}) begin
            fails++; $display("FAIL branch_counts got=%0d/%0d want=1/2", flush_count, stall_count);
        end
    endtask

    task automatic test_mem_stall();
        mem_stall = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            tests++;
            if (ctl !== CtlFreeze) begin
                fails++; $display("FAIL freeze_ctl[%0d] got=%b want=%b", i, ctl, CtlFreeze);
            end
            tick();
        end
        tests++;
        if (flush_count !== 16'd1) begin
            fails++; $display("FAIL freeze_flush_count got=%0d want=1", flush_count);
        end
        mem_stall = 1'b0;
        #2;
        tests++;
        if (ctl !== CtlFlush) begin
            fails++; $display("FAIL release_ctl got=%b want=%b", ctl, CtlFlush);
        end
        tick();
        idle_inputs();
        tests++;
        if ({flush_count, mem_err} !== {16'd2, 1'b0}) begin
            fails++; $display("FAIL release_state got=%0d/%b want=2/0", flush_count, mem_err);
        end
    endtask

    task automatic test_halt();
        id_halt = 1'b1;
        #2;
        tests++;
        if (ctl !== CtlBubble) begin
            fails++; $display("FAIL halt_detect_ctl got=%b want=%b", ctl, CtlBubble);
        end
        tick();
        id_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // Branch and load-use in the middle drain cycle must be ignored.
            if (i == 1) begin
                ex_branch_taken = 1'b1;
                IDEXMemRead = 1'b1; idex_dst = 4'd4; ifid_rs = 4'd4; ifid_uses_rs = 1'b1;
            end
            #2;
            tests++;
            if ({ctl, halted} !== {CtlBubble, 1'b0}) begin
                fails++; $display("FAIL drain_ctl[%0d] got=%b/%b want=%b/0", i, ctl, halted, CtlBubble);
            end
            tick();
            idle_inputs();
        end
        tests++;
        if ({halted, ctl, flush_count, stall_count} !== {1'b1, CtlReset, 16'd2, 16'd2}) begin
            fails++; $display("FAIL halted_entry got=%b/%b/%0d/%0d want=1/%b/2/2",
                              halted, ctl, flush_count, stall_count, CtlReset);
        end
        for (int i = 0; i < 20; i++) begin
            ex_branch_taken = i[0];
            id_halt         = i[1];
            #2;
            tests++;
            if ({halted, ctl} !== {1'b1, CtlReset}) begin
                fails++; $display("FAIL halted_hold[%0d] got=%b/%b want=1/%b", i, halted, ctl, CtlReset);
            end
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        tests++;
        if ({halted, ctl, flush_count, stall_count} !== {1'b0, CtlNormal, 32'd0}) begin
            fails++; $display("FAIL halt_reset got=%b/%b/%0d/%0d want=0/%b/0/0",
                              halted, ctl, flush_count, stall_count, CtlNormal);
        end
    endtask

    task automatic test_drain_freeze();
        id_halt = 1'b1;
        tick();
        id_halt = 1'b0;
        #2;
        tests++;
        if (ctl !== CtlBubble) begin
            fails++; $display("FAIL dfreeze_d0 got=%b want=%b", ctl, CtlBubble);
        end
        tick();
        mem_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            tests++;
            if (ctl !== CtlFreeze) begin
                fails++; $display("FAIL dfreeze_hold[%0d] got=%b want=%b", i, ctl, CtlFreeze);
            end
            tick();
        end
        mem_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            tests++;
            if ({ctl, halted} !== {CtlBubble, 1'b0}) begin
                fails++; $display("FAIL dfreeze_tail[%0d] got=%b/%b want=%b/0", i, ctl, halted, CtlBubble);
            end
            tick();
        end
        tests++;
        if ({halted, mem_err} !== 2'b10) begin
            fails++; $display("FAIL dfreeze_halted got=%b%b want=10", halted, mem_err);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_mem_timeout();
        mem_stall = 1'b1;
        repeat (7) tick();
        mem_stall = 1'b0;
        #2;
        tests++;
        if ({mem_err, halted, ctl} !== {2'b00, CtlNormal}) begin
            fails++; $display("FAIL stall7 got=%b/%b/%b want=0/0/%b", mem_err, halted, ctl, CtlNormal);
        end
        tick();
        mem_stall = 1'b1;
        repeat (7) tick();
        tests++;
        if (mem_err !== 1'b0) begin
            fails++; $display("FAIL stall8_early got=%b want=0", mem_err);
        end
        tick();
        tests++;
        if ({mem_err, halted, ctl} !== {2'b11, CtlReset}) begin
            fails++; $display("FAIL stall8_timeout got=%b/%b/%b want=1/1/%b", mem_err, halted, ctl, CtlReset);
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        tests++;
        if ({mem_err, halted, ctl} !== {2'b00, CtlNormal}) begin
            fails++; $display("FAIL timeout_reset got=%b/%b/%b want=0/0/%b", mem_err, halted, ctl, CtlNormal);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_stall();
        test_halt();
        test_drain_freeze();
        test_mem_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
